// File: rtl/sigma_gpio_csr.sv
`default_nettype none
// ============================================================================
// Module   : sigma_gpio_csr
// Purpose  : Multi-port GPIO/CSR peripheral on the sigma tile xif bus
//            (MemSplit32). NPORTS groups of 32-bit OUT/IN registers behind a
//            decoded address window, per-byte write enables, 2-flop input
//            synchronisation and, optionally, per-port rising-edge capture
//            with a level interrupt.
// Option   : define SIGMA_GPIO_IRQ_EN to build EMASK/ESTAT, the s3 edge flop
//            and a live irq_o. Without it, offsets +0x8/+0xC read as zero and
//            irq_o is tied low.
// Ports    : clk_i, rst_i        clock, synchronous active-high reset
//            bus_req_i/we_i      request strobe, 1 = write
//            bus_addr_bi         byte address (bits [1:0] ignored)
//            bus_be_bi           byte enables for writes
//            bus_wdata_bi        write data
//            bus_ack_o           combinational accept (= window hit)
//            bus_resp_o          one-cycle read-data-valid, one cycle after
//                                the read request
//            bus_rdata_bo        read data, zero when bus_resp_o is low
//            gpio_bi             asynchronous inputs, port p at [32p+31:32p]
//            gpio_bo             registered outputs
//            irq_o               OR of every ESTAT bit, registered
// Revision : 1.0 - initial release
// ============================================================================
module sigma_gpio_csr #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          NPORTS    = 2,
   parameter logic [31:0] OUT_RST   = 32'h0000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   bus_req_i,
   input  logic                   bus_we_i,
   input  logic [31:0]            bus_addr_bi,
   input  logic [3:0]             bus_be_bi,
   input  logic [31:0]            bus_wdata_bi,
   output logic                   bus_ack_o,
   output logic                   bus_resp_o,
   output logic [31:0]            bus_rdata_bo,
   input  logic [NPORTS*32-1:0]   gpio_bi,
   output logic [NPORTS*32-1:0]   gpio_bo,
   output logic                   irq_o
);

   localparam int          c_W        = NPORTS * 32;
   localparam int          c_IDX_BITS = (NPORTS > 1) ? $clog2(NPORTS) : 0;
   // Window covers 16 bytes per port, rounded up to a power of two.
   localparam logic [31:0] c_WIN_MASK = ~((32'd16 << c_IDX_BITS) - 32'd1);
   localparam logic [2:0]  c_IDX_MASK = 3'((1 << c_IDX_BITS) - 1);
   localparam logic [2:0]  c_IDX_MAX  = 3'(NPORTS - 1);
   localparam logic [1:0]  c_OFF_OUT  = 2'd0;
   localparam logic [1:0]  c_OFF_IN   = 2'd1;

   function automatic logic [31:0] f_be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
      return m;
   endfunction

   // ---------------------------------------------------------------- decode
   logic [2:0]  w_idx;
   logic [1:0]  w_off;
   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic [31:0] w_wmask;

   assign w_idx   = bus_addr_bi[6:4] & c_IDX_MASK;
   assign w_off   = bus_addr_bi[3:2];
   // The index check only matters for non-power-of-two NPORTS, where the
   // rounded-up window contains indices with no port behind them.
   assign w_hit   = bus_req_i
                  & ((bus_addr_bi & c_WIN_MASK) == (BASE_ADDR & c_WIN_MASK))
                  & (w_idx <= c_IDX_MAX);
   assign w_wr    = w_hit & bus_we_i;
   assign w_rd    = w_hit & ~bus_we_i;
   assign w_wmask = f_be_mask(bus_be_bi);
   assign bus_ack_o = w_hit;

   // ---------------------------------------------------------- OUT registers
   logic [c_W-1:0] out_q, out_d;

   always_comb begin
      out_d = out_q;
      for (int p = 0; p < NPORTS; p++) begin
         if (w_wr && (w_off == c_OFF_OUT) && (w_idx == 3'(p)))
            out_d[p*32 +: 32] = (out_q[p*32 +: 32] & ~w_wmask)
                              | (bus_wdata_bi & w_wmask);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) out_q <= {NPORTS{OUT_RST}};
      else       out_q <= out_d;
   end

   assign gpio_bo = out_q;

   // ------------------------------------------------------- input sync chain
   logic [c_W-1:0] s1_q, s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= gpio_bi;
         s2_q <= s1_q;
      end
   end

`ifdef SIGMA_GPIO_IRQ_EN
   // ------------------------------------------------ edge capture and IRQ
   localparam logic [1:0] c_OFF_EMASK = 2'd2;
   localparam logic [1:0] c_OFF_ESTAT = 2'd3;

   logic [c_W-1:0] s3_q;
   logic [c_W-1:0] emask_q, emask_d;
   logic [c_W-1:0] estat_q, estat_d;
   logic [c_W-1:0] w_clr;
   logic           irq_q;

   always_comb begin
      emask_d = emask_q;
      w_clr   = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (w_wr && (w_idx == 3'(p))) begin
            if (w_off == c_OFF_EMASK)
               emask_d[p*32 +: 32] = (emask_q[p*32 +: 32] & ~w_wmask)
                                   | (bus_wdata_bi & w_wmask);
            if (w_off == c_OFF_ESTAT)
               w_clr[p*32 +: 32] = bus_wdata_bi & w_wmask;
         end
      end
      // Set term is OR-ed last so a same-cycle rise beats a W1C clear.
      estat_d = (estat_q & ~w_clr) | (s2_q & ~s3_q & emask_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s3_q    <= '0;
         emask_q <= '0;
         estat_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         s3_q    <= s2_q;
         emask_q <= emask_d;
         estat_q <= estat_d;
         irq_q   <= |estat_q;
      end
   end

   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   // ------------------------------------------------------------- read path
   logic [31:0] w_rd_data;

   always_comb begin
      w_rd_data = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (w_idx == 3'(p)) begin
            case (w_off)
               c_OFF_OUT:   w_rd_data = out_q[p*32 +: 32];
               c_OFF_IN:    w_rd_data = s2_q[p*32 +: 32];
`ifdef SIGMA_GPIO_IRQ_EN
               c_OFF_EMASK: w_rd_data = emask_q[p*32 +: 32];
               c_OFF_ESTAT: w_rd_data = estat_q[p*32 +: 32];
`endif
               default:     w_rd_data = '0;
            endcase
         end
      end
   end

   logic        resp_q;
   logic [31:0] rdata_q;

   // rdata is zeroed on non-read cycles so the OR-ed bus mux stays clean.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         resp_q  <= w_rd;
         rdata_q <= w_rd ? w_rd_data : '0;
      end
   end

   assign bus_resp_o   = resp_q;
   assign bus_rdata_bo = rdata_q;

endmodule
`default_nettype wire
